// File: rtl/mips_exec_mem_unit.sv
// Single-cycle MIPS execute/memory slice: main decoder, 32-bit ALU and a word-addressed data memory.
// Decode, ALU and memory read are combinational; only the memory array is clocked.
module mips_exec_mem_unit #(
    parameter int DM_AW    = 8,
    parameter int DM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic [4:0]  shamt,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [31:0] ext_imm,
    output logic        jump,
    output logic        RegDst,
    output logic        Branch,
    output logic        MemR,
    output logic        Mem2R,
    output logic        MemW,
    output logic        RegW,
    output logic        Alusrc,
    output logic [1:0]  ExtOp,
    output logic [4:0]  Aluctrl,
    output logic [31:0] alu_out,
    output logic        zero,
    output logic [31:0] mem_rdata,
    output logic [31:0] wb_data
);
    localparam logic [4:0] ALU_ADD  = 5'd0,  ALU_SUB  = 5'd1,  ALU_AND  = 5'd2,  ALU_OR   = 5'd3;
    localparam logic [4:0] ALU_XOR  = 5'd4,  ALU_NOR  = 5'd5,  ALU_SLT  = 5'd6,  ALU_SLTU = 5'd7;
    localparam logic [4:0] ALU_SLL  = 5'd8,  ALU_SRL  = 5'd9,  ALU_SRA  = 5'd10, ALU_SLLV = 5'd11;
    localparam logic [4:0] ALU_SRLV = 5'd12, ALU_SRAV = 5'd13, ALU_LUI  = 5'd14, ALU_BNE  = 5'd15;

    logic [31:0]      aluB;
    logic [DM_AW-1:0] wordIdx;
    logic [31:0]      memWords [DM_DEPTH];

    always_comb begin
        jump    = 1'b0;
        RegDst  = 1'b0;
        Branch  = 1'b0;
        MemR    = 1'b0;
        Mem2R   = 1'b0;
        MemW    = 1'b0;
        RegW    = 1'b0;
        Alusrc  = 1'b0;
        ExtOp   = 2'b00;
        Aluctrl = ALU_ADD;
        case (op)
            6'h00: begin
                RegDst = 1'b1;
                RegW   = 1'b1;
                case (funct)
                    6'h20, 6'h21: Aluctrl = ALU_ADD;
                    6'h22, 6'h23: Aluctrl = ALU_SUB;
                    6'h24:        Aluctrl = ALU_AND;
                    6'h25:        Aluctrl = ALU_OR;
                    6'h26:        Aluctrl = ALU_XOR;
                    6'h27:        Aluctrl = ALU_NOR;
                    6'h2A:        Aluctrl = ALU_SLT;
                    6'h2B:        Aluctrl = ALU_SLTU;
                    6'h00:        Aluctrl = ALU_SLL;
                    6'h02:        Aluctrl = ALU_SRL;
                    6'h03:        Aluctrl = ALU_SRA;
                    6'h04:        Aluctrl = ALU_SLLV;
                    6'h06:        Aluctrl = ALU_SRLV;
                    6'h07:        Aluctrl = ALU_SRAV;
                    default: begin
                        // Unknown funct behaves as a bubble: no write-back.
                        RegDst = 1'b0;
                        RegW   = 1'b0;
                    end
                endcase
            end
            6'h08, 6'h09: begin RegW = 1'b1; Alusrc = 1'b1; ExtOp = 2'b01; Aluctrl = ALU_ADD;  end
            6'h0A:        begin RegW = 1'b1; Alusrc = 1'b1; ExtOp = 2'b01; Aluctrl = ALU_SLT;  end
            6'h0B:        begin RegW = 1'b1; Alusrc = 1'b1; ExtOp = 2'b01; Aluctrl = ALU_SLTU; end
            6'h0C:        begin RegW = 1'b1; Alusrc = 1'b1; ExtOp = 2'b00; Aluctrl = ALU_AND;  end
            6'h0D:        begin RegW = 1'b1; Alusrc = 1'b1; ExtOp = 2'b00; Aluctrl = ALU_OR;   end
            6'h0E:        begin RegW = 1'b1; Alusrc = 1'b1; ExtOp = 2'b00; Aluctrl = ALU_XOR;  end
            6'h0F:        begin RegW = 1'b1; Alusrc = 1'b1; ExtOp = 2'b10; Aluctrl = ALU_LUI;  end
            6'h23: begin
                Alusrc = 1'b1; ExtOp = 2'b01; MemR = 1'b1; Mem2R = 1'b1; RegW = 1'b1;
            end
            6'h2B:        begin Alusrc = 1'b1; ExtOp = 2'b01; MemW = 1'b1; end
            6'h04:        begin Branch = 1'b1; ExtOp = 2'b01; Aluctrl = ALU_SUB; end
            6'h05:        begin Branch = 1'b1; ExtOp = 2'b01; Aluctrl = ALU_BNE; end
            6'h02:        jump = 1'b1;
            default: ;
        endcase
    end

    assign aluB = Alusrc ? ext_imm : rt_data;

    always_comb begin
        case (Aluctrl)
            ALU_ADD:  alu_out = rs_data + aluB;
            ALU_SUB:  alu_out = rs_data - aluB;
            ALU_AND:  alu_out = rs_data & aluB;
            ALU_OR:   alu_out = rs_data | aluB;
            ALU_XOR:  alu_out = rs_data ^ aluB;
            ALU_NOR:  alu_out = ~(rs_data | aluB);
            ALU_SLT:  alu_out = {31'b0, $signed(rs_data) < $signed(aluB)};
            ALU_SLTU: alu_out = {31'b0, rs_data < aluB};
            ALU_SLL:  alu_out = aluB << shamt;
            ALU_SRL:  alu_out = aluB >> shamt;
            ALU_SRA:  alu_out = $signed(aluB) >>> shamt;
            ALU_SLLV: alu_out = aluB << rs_data[4:0];
            ALU_SRLV: alu_out = aluB >> rs_data[4:0];
            ALU_SRAV: alu_out = $signed(aluB) >>> rs_data[4:0];
            ALU_LUI:  alu_out = aluB;
            ALU_BNE:  alu_out = rs_data - aluB;
            default:  alu_out = 32'b0;
        endcase
    end

    // BNE inverts the sense so Branch&zero still means "take the branch".
    assign zero = (Aluctrl == ALU_BNE) ? (alu_out != 32'b0) : (alu_out == 32'b0);

    // Byte offset and bits above the array size are dropped, so addresses wrap.
    assign wordIdx   = alu_out[DM_AW+1:2];
    assign mem_rdata = MemR ? memWords[wordIdx] : 32'b0;
    assign wb_data   = Mem2R ? mem_rdata : alu_out;

    // Reset must clear every word in one edge, so the array is register-based.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            for (int i = 0; i < DM_DEPTH; i++) begin
                memWords[i] <= 32'b0;
            end
        end else if (MemW) begin
            memWords[wordIdx] <= rt_data;
        end
    end
endmodule

// File: tb/tb_mips_exec_mem_unit.sv
// Bench for mips_exec_mem_unit: directed spec cases followed by random instructions,
// all compared against an instruction-level reference model with its own memory array.
module tb_mips_exec_mem_unit;
    logic        clk = 1'b0;
    logic        Reset;
    logic [5:0]  op, funct;
    logic [4:0]  shamt;
    logic [31:0] rs_data, rt_data, ext_imm;
    logic        jump, RegDst, Branch, MemR, Mem2R, MemW, RegW, Alusrc, zero;
    logic [1:0]  ExtOp;
    logic [4:0]  Aluctrl;
    logic [31:0] alu_out, mem_rdata, wb_data;

    int checks = 0;
    int errors = 0;
    int txn    = 0;
    logic [31:0] refMem [256];

    typedef struct packed {
        logic       jump, regDst, branch, memR, mem2R, memW, regW, aluSrc;
        logic [1:0] extOp;
        logic [4:0] aluCtrl;
    } ctrl_t;

    always #5 clk = ~clk;

    mips_exec_mem_unit #(.DM_AW(8), .DM_DEPTH(256)) dut (
        .clk(clk), .Reset(Reset), .op(op), .funct(funct), .shamt(shamt),
        .rs_data(rs_data), .rt_data(rt_data), .ext_imm(ext_imm),
        .jump(jump), .RegDst(RegDst), .Branch(Branch), .MemR(MemR), .Mem2R(Mem2R),
        .MemW(MemW), .RegW(RegW), .Alusrc(Alusrc), .ExtOp(ExtOp), .Aluctrl(Aluctrl),
        .alu_out(alu_out), .zero(zero), .mem_rdata(mem_rdata), .wb_data(wb_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Instruction semantics: each mnemonic computes its result directly from its operands.
    function automatic void refModel(input logic [5:0] o, input logic [5:0] f, input logic [4:0] sh,
                                     input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                                     output ctrl_t c, output logic [31:0] y, output logic z);
        logic isBne;
        c = '0;
        isBne = 1'b0;
        y = a + b;
        case (o)
            6'h00: begin
                c.regDst = 1'b1; c.regW = 1'b1;
                case (f)
                    6'h20, 6'h21: begin c.aluCtrl = 0;  y = a + b; end
                    6'h22, 6'h23: begin c.aluCtrl = 1;  y = a - b; end
                    6'h24: begin c.aluCtrl = 2;  y = a & b; end
                    6'h25: begin c.aluCtrl = 3;  y = a | b; end
                    6'h26: begin c.aluCtrl = 4;  y = a ^ b; end
                    6'h27: begin c.aluCtrl = 5;  y = ~(a | b); end
                    6'h2A: begin c.aluCtrl = 6;  y = ($signed(a) < $signed(b)) ? 1 : 0; end
                    6'h2B: begin c.aluCtrl = 7;  y = (a < b) ? 1 : 0; end
                    6'h00: begin c.aluCtrl = 8;  y = b << sh; end
                    6'h02: begin c.aluCtrl = 9;  y = b >> sh; end
                    6'h03: begin c.aluCtrl = 10; y = $signed(b) >>> sh; end
                    6'h04: begin c.aluCtrl = 11; y = b << a[4:0]; end
                    6'h06: begin c.aluCtrl = 12; y = b >> a[4:0]; end
                    6'h07: begin c.aluCtrl = 13; y = $signed(b) >>> a[4:0]; end
                    default: begin c = '0; y = a + b; end
                endcase
            end
            6'h08, 6'h09: begin c.regW = 1; c.aluSrc = 1; c.extOp = 2'b01; y = a + imm; end
            6'h0A: begin c.regW = 1; c.aluSrc = 1; c.extOp = 2'b01; c.aluCtrl = 6;
                         y = ($signed(a) < $signed(imm)) ? 1 : 0; end
            6'h0B: begin c.regW = 1; c.aluSrc = 1; c.extOp = 2'b01; c.aluCtrl = 7;
                         y = (a < imm) ? 1 : 0; end
            6'h0C: begin c.regW = 1; c.aluSrc = 1; c.aluCtrl = 2; y = a & imm; end
            6'h0D: begin c.regW = 1; c.aluSrc = 1; c.aluCtrl = 3; y = a | imm; end
            6'h0E: begin c.regW = 1; c.aluSrc = 1; c.aluCtrl = 4; y = a ^ imm; end
            6'h0F: begin c.regW = 1; c.aluSrc = 1; c.extOp = 2'b10; c.aluCtrl = 14; y = imm; end
            6'h23: begin c.aluSrc = 1; c.extOp = 2'b01; c.memR = 1; c.mem2R = 1; c.regW = 1; y = a + imm; end
            6'h2B: begin c.aluSrc = 1; c.extOp = 2'b01; c.memW = 1; y = a + imm; end
            6'h04: begin c.branch = 1; c.extOp = 2'b01; c.aluCtrl = 1; y = a - b; end
            6'h05: begin c.branch = 1; c.extOp = 2'b01; c.aluCtrl = 15; y = a - b; isBne = 1; end
            6'h02: c.jump = 1;
            default: ;
        endcase
        z = isBne ? (a != b) : (y == 0);
    endfunction

    // Applies one instruction, checks every output, then clocks it and updates the model memory.
    task automatic run(input logic rst, input logic [5:0] o, input logic [5:0] f, input logic [4:0] sh,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
        ctrl_t c;
        logic [31:0] y, expRd;
        logic z;
        Reset = rst; op = o; funct = f; shamt = sh; rs_data = a; rt_data = b; ext_imm = imm;
        #1;
        refModel(o, f, sh, a, b, imm, c, y, z);
        expRd = c.memR ? refMem[y[9:2]] : 32'b0;
        chk("ctrl", {17'b0, jump, RegDst, Branch, MemR, Mem2R, MemW, RegW, Alusrc, ExtOp, Aluctrl},
            {17'b0, c});
        chk("alu_out", alu_out, y);
        chk("zero", {31'b0, zero}, {31'b0, z});
        chk("mem_rdata", mem_rdata, expRd);
        chk("wb_data", wb_data, c.mem2R ? expRd : y);
        $display("txn %0d rst=%b op=%h funct=%h a=%h b=%h imm=%h alu=%h zero=%b wb=%h",
                 txn, rst, o, f, a, b, imm, alu_out, zero, wb_data);
        txn++;
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < 256; i++) refMem[i] = 32'b0;
        end else if (c.memW) begin
            refMem[y[9:2]] = b;
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) refMem[i] = 32'b0;
        Reset = 1'b0; op = 6'h00; funct = 6'h20; shamt = 0; rs_data = 0; rt_data = 0; ext_imm = 0;
        @(posedge clk);
        #1;
        // Freshly cleared memory read
        run(1, 6'h23, 0, 0, 32'h0, 32'h0, 32'h0);
        chk("t1_memr", {31'b0, MemR}, 32'd1);
        chk("t1_rdata", mem_rdata, 32'h0);
        // Store then load, including a wrapped address
        run(1, 6'h2B, 0, 0, 32'h10, 32'hDEADBEEF, 32'h4);
        run(1, 6'h23, 0, 0, 32'h10, 32'h0, 32'h4);
        chk("t2_lw", wb_data, 32'hDEADBEEF);
        run(1, 6'h23, 0, 0, 32'h414, 32'h0, 32'h0);
        chk("t2_wrap", wb_data, 32'hDEADBEEF);
        // R-type spot values
        run(1, 6'h00, 6'h22, 0, 32'd7, 32'd9, 0);
        chk("t3_sub", alu_out, 32'hFFFFFFFE);
        run(1, 6'h00, 6'h2A, 0, 32'hFFFFFFFF, 32'd1, 0);
        chk("t3_slt", alu_out, 32'd1);
        run(1, 6'h00, 6'h2B, 0, 32'hFFFFFFFF, 32'd1, 0);
        chk("t3_sltu", alu_out, 32'd0);
        run(1, 6'h00, 6'h03, 5'd4, 32'h0, 32'h80000000, 0);
        chk("t3_sra", alu_out, 32'hF8000000);
        run(1, 6'h00, 6'h27, 0, 32'h0, 32'h0, 0);
        chk("t3_nor", alu_out, 32'hFFFFFFFF);
        // Branch flags
        run(1, 6'h04, 0, 0, 32'd5, 32'd5, 0);
        chk("t4_beq_eq", {30'b0, Branch, zero}, 32'd3);
        run(1, 6'h04, 0, 0, 32'd5, 32'd6, 0);
        chk("t4_beq_ne", {30'b0, Branch, zero}, 32'd2);
        run(1, 6'h05, 0, 0, 32'd5, 32'd6, 0);
        chk("t4_bne", {30'b0, Branch, zero}, 32'd3);
        // Immediates
        run(1, 6'h0F, 0, 0, 32'h0, 32'h0, 32'h12340000);
        chk("t5_lui", alu_out, 32'h12340000);
        chk("t5_lui_ext", {30'b0, ExtOp}, 32'd2);
        run(1, 6'h0D, 0, 0, 32'hF0, 32'h0, 32'h0F);
        chk("t5_ori", alu_out, 32'hFF);
        chk("t5_ori_ext", {30'b0, ExtOp}, 32'd0);
        // Jump, undefined op, store blocked by reset
        run(1, 6'h02, 0, 0, 32'h1, 32'h2, 32'h3);
        chk("t6_j", {29'b0, jump, RegW, MemW}, 32'd4);
        run(1, 6'h3F, 0, 0, 32'h1, 32'h2, 32'h3);
        chk("t6_undef", {25'b0, jump, RegDst, Branch, MemR, Mem2R, MemW, RegW}, 32'd0);
        run(0, 6'h2B, 0, 0, 32'h40, 32'h12345678, 32'h0);
        run(1, 6'h23, 0, 0, 32'h40, 32'h0, 32'h0);
        chk("t6_rst_sw", mem_rdata, 32'h0);
        // Reset after a populated memory must clear old data
        run(1, 6'h2B, 0, 0, 32'h80, 32'hCAFEF00D, 32'h0);
        run(0, 6'h00, 6'h20, 0, 32'h0, 32'h0, 32'h0);
        run(1, 6'h23, 0, 0, 32'h80, 32'h0, 32'h0);
        chk("t6_rst_clear", mem_rdata, 32'h0);

        // Random instructions over a small address window so loads hit earlier stores
        for (int n = 0; n < 400; n++) begin
            logic [5:0]  opList [16];
            logic [5:0]  fnList [18];
            logic [31:0] a, b, imm;
            logic [5:0]  o, f;
            opList = '{6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E,
                       6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F, 6'h01};
            fnList = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                       6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h01, 6'h3F};
            o = opList[$urandom_range(0, 15)];
            if (o == 6'h23 || o == 6'h2B) o = ($urandom_range(0, 1) == 0) ? 6'h23 : 6'h2B;
            f = fnList[$urandom_range(0, 17)];
            a = $urandom;
            b = $urandom;
            imm = $urandom;
            if (o == 6'h23 || o == 6'h2B) begin
                a = 32'($urandom_range(0, 31)) << 2;
                imm = ($urandom_range(0, 3) == 0) ? 32'h400 : 32'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 3) == 0) b = a;
            run(($urandom_range(0, 39) != 0), o, f, 5'($urandom), a, b, imm);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
